// File: rtl/control_sequencer.sv
// control_sequencer
//   Fetch/execute T-state sequencer for the shared 8-bit bus. A T-state
//   counter advances one step per clk while running. The 4-bit opcode is
//   decoded into a Moore control word that drives the ie/oe/step pins of the
//   bus modules.
//
//   Build option: define SEQ_EXT_OPCODES_EN to add STA/LDI/JMP. When it is
//   undefined, those opcodes decode as NOP and ram_ie/pc_ie stay at 0.
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset
//   run      1 = advance one T-state per clk, 0 = freeze and mask controls
//   opcode   upper nibble of the instruction register
//   tstate   current T-state, 0-based (0 = T1)
//   halted   sticky halt flag, cleared only by rst
//   pc_oe .. out_ie   per-cycle bus control lines

module control_sequencer #(
    parameter int T_STATES = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        run,
    input  logic [3:0]                  opcode,
    output logic [$clog2(T_STATES)-1:0] tstate,
    output logic                        halted,
    output logic                        pc_oe,
    output logic                        pc_step,
    output logic                        pc_ie,
    output logic                        mar_ie,
    output logic                        ram_oe,
    output logic                        ram_ie,
    output logic                        ir_ie,
    output logic                        ir_oe,
    output logic                        a_ie,
    output logic                        a_oe,
    output logic                        b_ie,
    output logic                        alu_oe,
    output logic                        alu_sub,
    output logic                        out_ie
);

    // state  | meaning
    // S_RUN  | T-state counter advances while run=1
    // S_HALT | HLT executed; counter frozen at T4, all controls masked

    localparam int TW = $clog2(T_STATES);

`ifdef SEQ_EXT_OPCODES_EN
    localparam bit EXT_EN = 1'b1;
`else
    localparam bit EXT_EN = 1'b0;
`endif

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic {S_RUN, S_HALT} mode_t;

    mode_t          mode, mode_nxt;
    logic [TW-1:0]  tstate_nxt;
    int unsigned    t_idx;
    logic           ctrl_en;

    // Widened copy so T5/T6 decode cannot alias onto a narrow counter.
    assign t_idx  = 32'(tstate);
    assign halted = (mode == S_HALT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode   <= S_RUN;
            tstate <= '0;
        end else begin
            mode   <= mode_nxt;
            tstate <= tstate_nxt;
        end
    end

    always_comb begin
        mode_nxt   = mode;
        tstate_nxt = tstate;
        case (mode)
            S_RUN: begin
                if (run) begin
                    // HLT freezes the counter on T4 instead of advancing.
                    if (t_idx == 32'd3 && opcode == OP_HLT)
                        mode_nxt = S_HALT;
                    else if (t_idx == 32'(T_STATES - 1))
                        tstate_nxt = '0;
                    else
                        tstate_nxt = tstate + TW'(1);
                end
            end
            S_HALT: ;
            default: mode_nxt = S_RUN;
        endcase
    end

    // The rst term keeps the T1 word off the bus while reset is held.
    assign ctrl_en = rst & run & (mode == S_RUN);

    always_comb begin
        pc_oe   = 1'b0;
        pc_step = 1'b0;
        pc_ie   = 1'b0;
        mar_ie  = 1'b0;
        ram_oe  = 1'b0;
        ram_ie  = 1'b0;
        ir_ie   = 1'b0;
        ir_oe   = 1'b0;
        a_ie    = 1'b0;
        a_oe    = 1'b0;
        b_ie    = 1'b0;
        alu_oe  = 1'b0;
        alu_sub = 1'b0;
        out_ie  = 1'b0;
        if (ctrl_en) begin
            case (t_idx)
                32'd0: begin
                    pc_oe  = 1'b1;
                    mar_ie = 1'b1;
                end
                32'd1: pc_step = 1'b1;
                32'd2: begin
                    ram_oe = 1'b1;
                    ir_ie  = 1'b1;
                end
                32'd3: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ir_oe  = 1'b1;
                            mar_ie = 1'b1;
                        end
                        OP_OUT: begin
                            a_oe   = 1'b1;
                            out_ie = 1'b1;
                        end
                        OP_STA: begin
                            ir_oe  = EXT_EN;
                            mar_ie = EXT_EN;
                        end
                        OP_LDI: begin
                            ir_oe = EXT_EN;
                            a_ie  = EXT_EN;
                        end
                        OP_JMP: begin
                            ir_oe = EXT_EN;
                            pc_ie = EXT_EN;
                        end
                        default: ;
                    endcase
                end
                32'd4: begin
                    case (opcode)
                        OP_LDA: begin
                            ram_oe = 1'b1;
                            a_ie   = 1'b1;
                        end
                        OP_ADD: begin
                            ram_oe = 1'b1;
                            b_ie   = 1'b1;
                        end
                        OP_SUB: begin
                            ram_oe  = 1'b1;
                            b_ie    = 1'b1;
                            alu_sub = 1'b1;
                        end
                        OP_STA: begin
                            a_oe   = EXT_EN;
                            ram_ie = EXT_EN;
                        end
                        default: ;
                    endcase
                end
                32'd5: begin
                    case (opcode)
                        OP_ADD: begin
                            alu_oe = 1'b1;
                            a_ie   = 1'b1;
                        end
                        OP_SUB: begin
                            alu_oe  = 1'b1;
                            a_ie    = 1'b1;
                            alu_sub = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//   Directed table-driven bench for control_sequencer (T_STATES=6), plus
//   hand-written sequences for halt and asynchronous reset mid-instruction.

module tb_control_sequencer;

    localparam logic [13:0] PC_OE   = 14'h2000;
    localparam logic [13:0] PC_STEP = 14'h1000;
    localparam logic [13:0] PC_IE   = 14'h0800;
    localparam logic [13:0] MAR_IE  = 14'h0400;
    localparam logic [13:0] RAM_OE  = 14'h0200;
    localparam logic [13:0] RAM_IE  = 14'h0100;
    localparam logic [13:0] IR_IE   = 14'h0080;
    localparam logic [13:0] IR_OE   = 14'h0040;
    localparam logic [13:0] A_IE    = 14'h0020;
    localparam logic [13:0] A_OE    = 14'h0010;
    localparam logic [13:0] B_IE    = 14'h0008;
    localparam logic [13:0] ALU_OE  = 14'h0004;
    localparam logic [13:0] ALU_SUB = 14'h0002;
    localparam logic [13:0] OUT_IE  = 14'h0001;
    localparam logic [13:0] NONE    = 14'h0000;

    localparam logic [13:0] F1 = PC_OE | MAR_IE;
    localparam logic [13:0] F2 = PC_STEP;
    localparam logic [13:0] F3 = RAM_OE | IR_IE;

`ifdef SEQ_EXT_OPCODES_EN
    localparam logic [13:0] JMP_T4 = IR_OE | PC_IE;
    localparam logic [13:0] STA_T4 = IR_OE | MAR_IE;
    localparam logic [13:0] STA_T5 = A_OE | RAM_IE;
    localparam logic [13:0] LDI_T4 = IR_OE | A_IE;
`else
    localparam logic [13:0] JMP_T4 = NONE;
    localparam logic [13:0] STA_T4 = NONE;
    localparam logic [13:0] STA_T5 = NONE;
    localparam logic [13:0] LDI_T4 = NONE;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [3:0] opcode;
    logic [2:0] tstate;
    logic       halted;
    logic       pc_oe, pc_step, pc_ie, mar_ie, ram_oe, ram_ie, ir_ie;
    logic       ir_oe, a_ie, a_oe, b_ie, alu_oe, alu_sub, out_ie;
    logic [13:0] ctrl;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    control_sequencer #(.T_STATES(6)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode),
        .tstate(tstate), .halted(halted),
        .pc_oe(pc_oe), .pc_step(pc_step), .pc_ie(pc_ie), .mar_ie(mar_ie),
        .ram_oe(ram_oe), .ram_ie(ram_ie), .ir_ie(ir_ie), .ir_oe(ir_oe),
        .a_ie(a_ie), .a_oe(a_oe), .b_ie(b_ie), .alu_oe(alu_oe),
        .alu_sub(alu_sub), .out_ie(out_ie)
    );

    assign ctrl = {pc_oe, pc_step, pc_ie, mar_ie, ram_oe, ram_ie, ir_ie,
                   ir_oe, a_ie, a_oe, b_ie, alu_oe, alu_sub, out_ie};

    typedef struct {
        logic        rst;
        logic        run;
        logic [3:0]  op;
        int          ts;
        logic        h;
        logic [13:0] c;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic ru, input logic [3:0] op,
                       input int ts, input logic h, input logic [13:0] c);
        vq.push_back('{r, ru, op, ts, h, c});
    endtask

    task automatic chk(input string name, input int ts, input logic h,
                       input logic [13:0] c);
        n_cmp++;
        if (int'(tstate) != ts) begin
            n_bad++;
            $display("FAIL %s tstate: got %0d want %0d", name, tstate, ts);
        end
        n_cmp++;
        if (halted !== h) begin
            n_bad++;
            $display("FAIL %s halted: got %b want %b", name, halted, h);
        end
        n_cmp++;
        if (ctrl !== c) begin
            n_bad++;
            $display("FAIL %s ctrl: got %014b want %014b", name, ctrl, c);
        end
        n_cmp++;
        if ($countones({pc_oe, ram_oe, ir_oe, a_oe, alu_oe}) > 1) begin
            n_bad++;
            $display("FAIL %s bus_oe: got %05b want at most one set", name,
                     {pc_oe, ram_oe, ir_oe, a_oe, alu_oe});
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; run = 1'b1; opcode = 4'b0001;
        tick();

        // reset held, then ADD
        add(0, 1, 4'h1, 0, 0, NONE);
        add(0, 1, 4'h1, 0, 0, NONE);
        add(1, 1, 4'h1, 0, 0, F1);
        add(1, 1, 4'h1, 1, 0, F2);
        add(1, 1, 4'h1, 2, 0, F3);
        add(1, 1, 4'h1, 3, 0, IR_OE | MAR_IE);
        add(1, 1, 4'h1, 4, 0, RAM_OE | B_IE);
        add(1, 1, 4'h1, 5, 0, ALU_OE | A_IE);
        // SUB, starting from the 5->0 wrap
        add(1, 1, 4'h2, 0, 0, F1);
        add(1, 1, 4'h2, 1, 0, F2);
        add(1, 1, 4'h2, 2, 0, F3);
        add(1, 1, 4'h2, 3, 0, IR_OE | MAR_IE);
        add(1, 1, 4'h2, 4, 0, RAM_OE | B_IE | ALU_SUB);
        add(1, 1, 4'h2, 5, 0, ALU_OE | A_IE | ALU_SUB);
        // LDA with a 3-cycle stall in T5
        add(1, 1, 4'h0, 0, 0, F1);
        add(1, 1, 4'h0, 1, 0, F2);
        add(1, 1, 4'h0, 2, 0, F3);
        add(1, 1, 4'h0, 3, 0, IR_OE | MAR_IE);
        add(1, 0, 4'h0, 4, 0, NONE);
        add(1, 0, 4'h0, 4, 0, NONE);
        add(1, 0, 4'h0, 4, 0, NONE);
        add(1, 1, 4'h0, 4, 0, RAM_OE | A_IE);
        add(1, 1, 4'h0, 5, 0, NONE);
        // OUT
        add(1, 1, 4'hE, 0, 0, F1);
        add(1, 1, 4'hE, 1, 0, F2);
        add(1, 1, 4'hE, 2, 0, F3);
        add(1, 1, 4'hE, 3, 0, A_OE | OUT_IE);
        add(1, 1, 4'hE, 4, 0, NONE);
        add(1, 1, 4'hE, 5, 0, NONE);
        // JMP
        add(1, 1, 4'h6, 0, 0, F1);
        add(1, 1, 4'h6, 1, 0, F2);
        add(1, 1, 4'h6, 2, 0, F3);
        add(1, 1, 4'h6, 3, 0, JMP_T4);
        add(1, 1, 4'h6, 4, 0, NONE);
        add(1, 1, 4'h6, 5, 0, NONE);
        // STA
        add(1, 1, 4'h4, 0, 0, F1);
        add(1, 1, 4'h4, 1, 0, F2);
        add(1, 1, 4'h4, 2, 0, F3);
        add(1, 1, 4'h4, 3, 0, STA_T4);
        add(1, 1, 4'h4, 4, 0, STA_T5);
        add(1, 1, 4'h4, 5, 0, NONE);
        // LDI
        add(1, 1, 4'h5, 0, 0, F1);
        add(1, 1, 4'h5, 1, 0, F2);
        add(1, 1, 4'h5, 2, 0, F3);
        add(1, 1, 4'h5, 3, 0, LDI_T4);
        add(1, 1, 4'h5, 4, 0, NONE);
        add(1, 1, 4'h5, 5, 0, NONE);
        // unassigned opcode 0011 is NOP in execute
        add(1, 1, 4'h3, 0, 0, F1);
        add(1, 1, 4'h3, 1, 0, F2);
        add(1, 1, 4'h3, 2, 0, F3);
        add(1, 1, 4'h3, 3, 0, NONE);
        add(1, 1, 4'h3, 4, 0, NONE);
        add(1, 1, 4'h3, 5, 0, NONE);

        foreach (vq[i]) begin
            rst = vq[i].rst; run = vq[i].run; opcode = vq[i].op;
            #1;
            chk($sformatf("vec%0d", i), vq[i].ts, vq[i].h, vq[i].c);
            tick();
        end

        // HLT: counter freezes on T4, controls masked, sticky until rst
        rst = 1'b1; run = 1'b1; opcode = 4'hF;
        #1 chk("hlt_t1", 0, 0, F1);  tick();
        chk("hlt_t2", 1, 0, F2);     tick();
        chk("hlt_t3", 2, 0, F3);     tick();
        chk("hlt_t4", 3, 0, NONE);   tick();
        for (int k = 0; k < 10; k++) begin
            if (k == 5) opcode = 4'h1;
            #1 chk($sformatf("hlt_stuck%0d", k), 3, 1, NONE);
            tick();
        end
        rst = 1'b0;
        #1 chk("hlt_rst", 0, 0, NONE);
        tick();

        // async reset in the middle of a fetch
        rst = 1'b1; opcode = 4'h1;
        #1 chk("mid_t1", 0, 0, F1);  tick();
        chk("mid_t2", 1, 0, F2);     tick();
        chk("mid_t3", 2, 0, F3);
        #2 rst = 1'b0;
        #1 chk("mid_rst", 0, 0, NONE);
        rst = 1'b1;
        #1 chk("mid_rel", 0, 0, F1);
        tick();
        chk("mid_after", 1, 0, F2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Initiator side of the shared 8-bit bus protocol. Generates the per-cycle ie/oe/step control lines that the bus registers, counters, RAM and ALU respond to.
- Implements the fetch/execute T-state machine. Decodes the 4-bit opcode from the instruction register into a Moore control word, one T-state per clk.
- Sits at top level beside the instruction register. Its outputs wire directly to the ie/oe/step pins of the other bus modules.

Parameters:
- T_STATES, 6, number of T-states per instruction; legal range 4..8; state counter width is $clog2(T_STATES).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- run  input  1  1 = advance one T-state per clk; 0 = freeze state and mask all controls.
- opcode  input  4  upper nibble of instruction register, sampled combinationally.
- tstate  output  $clog2(T_STATES)  current T-state, 0-based (0 = T1).
- halted  output  1  sticky halt flag.
- pc_oe  output  1  program counter drives bus.
- pc_step  output  1  program counter increments.
- pc_ie  output  1  program counter loads from bus (jump).
- mar_ie  output  1  memory address register loads.
- ram_oe  output  1  RAM drives bus.
- ram_ie  output  1  RAM writes from bus.
- ir_ie  output  1  instruction register loads.
- ir_oe  output  1  instruction register drives low nibble onto bus.
- a_ie  output  1  accumulator loads.
- a_oe  output  1  accumulator drives bus.
- b_ie  output  1  B register loads.
- alu_oe  output  1  ALU result drives bus.
- alu_sub  output  1  ALU subtract select.
- out_ie  output  1  output register loads.

Behaviour:
- Reset (rst=0, async): tstate=0, halted=0, all control outputs 0. Held for as long as rst=0.
- Advance: on rising clk with run=1 and halted=0, tstate increments; tstate=T_STATES-1 wraps to 0. Otherwise tstate holds.
- Controls are combinational from (tstate, opcode), ANDed with run & ~halted. With run=0 or halted=1 every control is 0, so no register loads repeatedly while stalled.
- Fetch, opcode-independent:
  - T1: pc_oe, mar_ie.
  - T2: pc_step.
  - T3: ram_oe, ir_ie.
- Execute T4/T5/T6 (states beyond T6 are NOP):
  - LDA 0000: T4 ir_oe+mar_ie; T5 ram_oe+a_ie; T6 none.
  - ADD 0001: T4 ir_oe+mar_ie; T5 ram_oe+b_ie; T6 alu_oe+a_ie.
  - SUB 0010: as ADD, with alu_sub asserted in both T5 and T6.
  - OUT 1110: T4 a_oe+out_ie; T5, T6 none.
  - HLT 1111: no controls. On the clk edge leaving T4, halted:=1 and tstate holds at 3. Sticky until rst.
  - Any other opcode: NOP for T4..T6.
- Bus invariant: at most one of pc_oe, ram_oe, ir_oe, a_oe, alu_oe is high in any cycle.
- Opcode changing mid-execute: outputs follow the new opcode combinationally. Stability is guaranteed by the ir_ie timing.
- Reset mid-instruction: immediate return to T1 with controls 0. No partial completion.

Optional Feature:
- Macro: SEQ_EXT_OPCODES_EN.
- Defined: adds three opcodes.
  - STA 0100: T4 ir_oe+mar_ie; T5 a_oe+ram_ie.
  - LDI 0101: T4 ir_oe+a_ie.
  - JMP 0110: T4 ir_oe+pc_ie.
- Undefined: 0100/0101/0110 decode as NOP. ram_ie and pc_ie remain ports, tied to 0.

Test Plan:
- rst=0 for 2 clk with run=1 -> tstate=0, halted=0, all controls 0. rst released -> next 3 clks show {pc_oe,mar_ie}, {pc_step}, {ram_oe,ir_ie}.
- opcode=0001 (ADD), run=1 for 6 clk -> T4 ir_oe+mar_ie, T5 ram_oe+b_ie, T6 alu_oe+a_ie with alu_sub=0. tstate wraps 5->0.
- opcode=0010 (SUB) -> same as ADD with alu_sub=1 in T5 and T6 only.
- opcode=1111 reaching T4 -> halted=1 after next edge, tstate stuck at 3, all controls 0 for 10 further clks. rst=0 clears.
- run=0 asserted during T5 of LDA for 3 clk -> tstate stays 4, controls 0. run=1 -> ram_oe+a_ie re-appear, then T6.
- SEQ_EXT_OPCODES_EN defined, opcode=0110 -> pc_ie+ir_oe in T4. Macro undefined -> all controls 0 in T4..T6.
- Every scenario: assert no two *_oe high in the same cycle.
